// File: rtl/mic_clk_ctrl.sv
// mic_clk_ctrl -- PDM microphone clock sequencer (i2s_clk domain).
//
// Starts/stops the microphone clock, switches it glitch-free between a
// normal and a low-power rate, and masks the settling samples that follow
// every start or rate change. Downstream logic qualifies each sample with
// sample_stb & data_valid.
//
// Optional feature macro: MIC_CLK_CTRL_LOWPWR_EN
//   defined   -> mode_req, HALF_LO and the PARK rate-switch path are active
//   undefined -> mode_req ignored, cur_mode tied 0, PARK unreachable
//
// Ports:
//   i2s_clk    in   clock
//   reset_n    in   asynchronous active-low reset
//   start      in   level; begins clocking from IDLE
//   stop       in   level; ends clocking (beats start and rate change)
//   mode_req   in   0 = normal (HALF_HI), 1 = low-power (HALF_LO)
//   mic_clk    out  registered microphone clock
//   sample_stb out  one-cycle pulse on each mic_clk rising edge
//   data_valid out  settling complete, samples usable
//   cur_mode   out  rate currently in effect
//   busy       out  sequencer not IDLE
module mic_clk_ctrl #(
    parameter int unsigned HALF_HI      = 4,
    parameter int unsigned HALF_LO      = 16,
    parameter int unsigned SETTLE_EDGES = 3,
    parameter int unsigned PARK_CYCLES  = 8
) (
    input  logic i2s_clk,
    input  logic reset_n,
    input  logic start,
    input  logic stop,
    input  logic mode_req,
    output logic mic_clk,
    output logic sample_stb,
    output logic data_valid,
    output logic cur_mode,
    output logic busy
);

    localparam int unsigned HALF_MAX = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;
    localparam int unsigned HCW = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int unsigned ECW = (SETTLE_EDGES > 1) ? $clog2(SETTLE_EDGES) : 1;
    localparam int unsigned PCW = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;

    localparam logic [HCW-1:0] TOP_HI   = HCW'(HALF_HI - 1);
    localparam logic [HCW-1:0] TOP_LO   = HCW'(HALF_LO - 1);
    localparam logic [ECW-1:0] EDGE_TOP = ECW'(SETTLE_EDGES - 1);
    localparam logic [PCW-1:0] PARK_TOP = PCW'(PARK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RUN,
        FINISH,
        PARK
    } state_t;

    state_t         state, state_nx;
    logic [HCW-1:0] half_ctr, half_ctr_nx;
    logic [ECW-1:0] edge_ctr, edge_ctr_nx;
    logic [PCW-1:0] park_ctr, park_ctr_nx;
    logic           fin_park, fin_park_nx;   // FINISH ends in PARK (1) or IDLE (0)
    logic           mic_clk_nx, stb_nx, valid_nx, mode_nx;
    logic           mode_in, half_end, rate_chg;

`ifdef MIC_CLK_CTRL_LOWPWR_EN
    assign mode_in = mode_req;
`else
    logic mode_req_unused;
    assign mode_req_unused = mode_req;
    assign mode_in         = 1'b0;
`endif

    assign half_end = (half_ctr == (cur_mode ? TOP_LO : TOP_HI));
    assign rate_chg = (mode_in != cur_mode);

    always_comb begin
        state_nx    = state;
        half_ctr_nx = half_ctr;
        edge_ctr_nx = edge_ctr;
        park_ctr_nx = park_ctr;
        fin_park_nx = fin_park;
        mic_clk_nx  = mic_clk;
        stb_nx      = 1'b0;
        valid_nx    = data_valid;
        mode_nx     = cur_mode;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx    = SETTLE;
                    mode_nx     = mode_in;
                    half_ctr_nx = '0;
                    edge_ctr_nx = '0;
                    mic_clk_nx  = 1'b0;
                end
            end

            SETTLE, RUN: begin
                if (half_end) begin
                    half_ctr_nx = '0;
                    mic_clk_nx  = !mic_clk;
                    stb_nx      = !mic_clk;
                end else begin
                    half_ctr_nx = half_ctr + 1'b1;
                end

                // Leaving while low (or on the falling toggle itself) ends
                // immediately; a rise due this cycle is suppressed. Leaving
                // while high lets FINISH complete the full high phase.
                if (stop) begin
                    valid_nx = 1'b0;
                    if (!mic_clk || half_end) begin
                        state_nx    = IDLE;
                        mic_clk_nx  = 1'b0;
                        stb_nx      = 1'b0;
                        half_ctr_nx = '0;
                    end else begin
                        state_nx    = FINISH;
                        fin_park_nx = 1'b0;
                    end
                end else if (rate_chg) begin
                    valid_nx = 1'b0;
                    if (!mic_clk || half_end) begin
                        state_nx    = PARK;
                        mic_clk_nx  = 1'b0;
                        stb_nx      = 1'b0;
                        half_ctr_nx = '0;
                        park_ctr_nx = '0;
                        mode_nx     = mode_in;
                    end else begin
                        state_nx    = FINISH;
                        fin_park_nx = 1'b1;
                    end
                end else if (state == SETTLE) begin
                    if (stb_nx) begin
                        edge_ctr_nx = edge_ctr + 1'b1;
                        if (edge_ctr == EDGE_TOP) begin
                            state_nx = RUN;
                        end
                    end
                end else begin
                    valid_nx = 1'b1;
                end
            end

            FINISH: begin
                if (half_end) begin
                    half_ctr_nx = '0;
                    mic_clk_nx  = 1'b0;
                    if (fin_park && !stop) begin
                        state_nx    = PARK;
                        park_ctr_nx = '0;
                        mode_nx     = mode_in;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    half_ctr_nx = half_ctr + 1'b1;
                end
            end

            PARK: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (park_ctr == PARK_TOP) begin
                    state_nx    = SETTLE;
                    park_ctr_nx = '0;
                    half_ctr_nx = '0;
                    edge_ctr_nx = '0;
                end else begin
                    park_ctr_nx = park_ctr + 1'b1;
                end
            end

            default: begin
                state_nx   = IDLE;
                mic_clk_nx = 1'b0;
                valid_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i2s_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            half_ctr   <= '0;
            edge_ctr   <= '0;
            park_ctr   <= '0;
            fin_park   <= 1'b0;
            mic_clk    <= 1'b0;
            sample_stb <= 1'b0;
            data_valid <= 1'b0;
            cur_mode   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            half_ctr   <= half_ctr_nx;
            edge_ctr   <= edge_ctr_nx;
            park_ctr   <= park_ctr_nx;
            fin_park   <= fin_park_nx;
            mic_clk    <= mic_clk_nx;
            sample_stb <= stb_nx;
            data_valid <= valid_nx;
            cur_mode   <= mode_nx;
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_mic_clk_ctrl.sv
// tb_mic_clk_ctrl -- self-checking bench for mic_clk_ctrl (default parameters).
//
// Expected sample_stb events (cycle number, data_valid) are queued when the
// stimulus that causes them is driven and popped as the strobes appear.
// High-phase lengths are checked against the rate the bench expects.
// Build with MIC_CLK_CTRL_LOWPWR_EN defined to exercise the rate-switch path.
module tb_mic_clk_ctrl;

    logic i2s_clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic mode_req = 1'b0;
    logic mic_clk, sample_stb, data_valid, cur_mode, busy;

    mic_clk_ctrl #(
        .HALF_HI      (4),
        .HALF_LO      (16),
        .SETTLE_EDGES (3),
        .PARK_CYCLES  (8)
    ) dut (
        .i2s_clk    (i2s_clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .mode_req   (mode_req),
        .mic_clk    (mic_clk),
        .sample_stb (sample_stb),
        .data_valid (data_valid),
        .cur_mode   (cur_mode),
        .busy       (busy)
    );

    always #5 i2s_clk = ~i2s_clk;

    int cyc = 0;
    always @(posedge i2s_clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int valid;
    } stb_exp_t;

    stb_exp_t sb[$];
    stb_exp_t e;

    task automatic push_stb(input int c, input int v);
        stb_exp_t x;
        x.cyc   = c;
        x.valid = v;
        sb.push_back(x);
    endtask

    // Edge n has been applied once cyc == n at a falling edge.
    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge i2s_clk);
    endtask

    int exp_half = 4;
    int hi_len = 0;
    logic prev_mic = 1'b0;

    always @(negedge i2s_clk) begin
        if (!reset_n) begin
            hi_len   = 0;
            prev_mic = 1'b0;
        end else begin
            if (sample_stb) begin
                if (sb.size() == 0) begin
                    check_val("stb_unexpected", int'(sample_stb), 0);
                end else begin
                    e = sb.pop_front();
                    check_val("stb_cyc", cyc, e.cyc);
                    check_val("stb_valid", int'(data_valid), e.valid);
                    check_val("stb_mic", int'(mic_clk), 1);
                end
            end
            if (mic_clk) begin
                hi_len++;
            end else if (prev_mic) begin
                check_val("hi_len", hi_len, exp_half);
                hi_len = 0;
            end
            prev_mic = mic_clk;
        end
    end

    task automatic check_outs(input string tag, input int m, input int s,
                              input int v, input int c, input int b);
        check_val({tag, "_mic"}, int'(mic_clk), m);
        check_val({tag, "_stb"}, int'(sample_stb), s);
        check_val({tag, "_valid"}, int'(data_valid), v);
        check_val({tag, "_mode"}, int'(cur_mode), c);
        check_val({tag, "_busy"}, int'(busy), b);
    endtask

    initial begin
        int s;
        // reset
        wait_edge(2);
        reset_n = 1'b1;
        wait_edge(5);
        check_outs("rst", 0, 0, 0, 0, 0);

        // start sampled at edge 10: rises every 8 from 14, valid from 31
        wait_edge(9);
        start = 1'b1;
        push_stb(14, 0); push_stb(22, 0); push_stb(30, 0);
        push_stb(38, 1); push_stb(46, 1); push_stb(54, 1);
        wait_edge(10);
        start = 1'b0;
        wait_edge(11);
        check_val("s1_busy", int'(busy), 1);
        wait_edge(30);
        check_val("s1_valid30", int'(data_valid), 0);
        wait_edge(31);
        check_val("s1_valid31", int'(data_valid), 1);

        // stop two cycles into the high phase that began at 54
        wait_edge(55);
        stop = 1'b1;
        wait_edge(56);
        stop = 1'b0;
        wait_edge(57);
        check_val("s2_mic57", int'(mic_clk), 1);
        check_val("s2_busy57", int'(busy), 1);
        check_val("s2_valid57", int'(data_valid), 0);
        wait_edge(58);
        check_val("s2_mic58", int'(mic_clk), 0);
        check_val("s2_busy58", int'(busy), 0);

        // start and stop together in IDLE
        wait_edge(69);
        start = 1'b1;
        stop  = 1'b1;
        wait_edge(74);
        start = 1'b0;
        stop  = 1'b0;
        wait_edge(75);
        check_outs("s4a", 0, 0, 0, 0, 0);

        // async reset two cycles into a high phase
        wait_edge(79);
        start = 1'b1;
        push_stb(84, 0); push_stb(92, 0);
        wait_edge(80);
        start = 1'b0;
        wait_edge(94);
        #2 reset_n = 1'b0;
        #1 check_outs("s5_rst", 0, 0, 0, 0, 0);
        wait_edge(96);
        reset_n = 1'b1;

        // clean restart, then stop while mic_clk is low
        wait_edge(99);
        start = 1'b1;
        push_stb(104, 0); push_stb(112, 0); push_stb(120, 0);
        push_stb(128, 1); push_stb(136, 1);
        wait_edge(100);
        start = 1'b0;
        wait_edge(120);
        check_val("s5_valid120", int'(data_valid), 0);
        wait_edge(121);
        check_val("s5_valid121", int'(data_valid), 1);
        wait_edge(141);
        stop = 1'b1;
        check_val("s5_busy141", int'(busy), 1);
        check_val("s5_mic141", int'(mic_clk), 0);
        wait_edge(142);
        stop = 1'b0;
        check_val("s5_busy142", int'(busy), 0);
        check_val("s5_mic142", int'(mic_clk), 0);

        s = 150;
`ifdef MIC_CLK_CTRL_LOWPWR_EN
        // switch to low power while low at s+34; PARK s+34..s+41, new rises every 32
        wait_edge(s - 1);
        start = 1'b1;
        push_stb(s + 4, 0); push_stb(s + 12, 0); push_stb(s + 20, 0);
        push_stb(s + 28, 1);
        wait_edge(s);
        start = 1'b0;
        wait_edge(s + 33);
        mode_req = 1'b1;
        push_stb(s + 58, 0); push_stb(s + 90, 0); push_stb(s + 122, 0);
        push_stb(s + 154, 1);
        wait_edge(s + 34);
        exp_half = 16;
        wait_edge(s + 35);
        check_outs("s3_park", 0, 0, 0, 1, 1);
        wait_edge(s + 41);
        check_val("s3_mic41", int'(mic_clk), 0);
        check_val("s3_busy41", int'(busy), 1);
        wait_edge(s + 122);
        check_val("s3_valid122", int'(data_valid), 0);
        wait_edge(s + 123);
        check_val("s3_valid123", int'(data_valid), 1);

        // back to normal rate while low, then stop inside PARK
        wait_edge(s + 171);
        mode_req = 1'b0;
        wait_edge(s + 173);
        check_outs("s4b_park", 0, 0, 0, 0, 1);
        wait_edge(s + 174);
        stop = 1'b1;
        check_val("s4b_busy174", int'(busy), 1);
        wait_edge(s + 175);
        stop = 1'b0;
        check_outs("s4b_idle", 0, 0, 0, 0, 0);
        wait_edge(s + 200);
`else
        // mode_req toggles in RUN have no effect without the low-power path
        wait_edge(s - 1);
        start = 1'b1;
        push_stb(s + 4, 0); push_stb(s + 12, 0); push_stb(s + 20, 0);
        push_stb(s + 28, 1); push_stb(s + 36, 1); push_stb(s + 44, 1);
        wait_edge(s);
        start = 1'b0;
        wait_edge(s + 29);
        mode_req = 1'b1;
        wait_edge(s + 31);
        check_val("s6_valid31", int'(data_valid), 1);
        wait_edge(s + 37);
        check_val("s6_valid37", int'(data_valid), 1);
        check_val("s6_mode37", int'(cur_mode), 0);
        wait_edge(s + 39);
        mode_req = 1'b0;
        wait_edge(s + 45);
        stop = 1'b1;
        wait_edge(s + 46);
        stop = 1'b0;
        wait_edge(s + 47);
        check_val("s6_busy47", int'(busy), 1);
        wait_edge(s + 48);
        check_val("s6_busy48", int'(busy), 0);
        check_val("s6_mic48", int'(mic_clk), 0);
        wait_edge(s + 80);
`endif
        check_val("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
